// File: rtl/hazard_pkg.sv
// Shared op-class encodings, default latencies and the result-latency lookup
// used by the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam logic [1:0] OP_ALU    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_MULDIV = 2'b10;

  localparam int unsigned HZ_LOAD_LAT = 1;
  localparam int unsigned HZ_MD_LAT   = 4;

  // Reserved class 2'b11 behaves as ALU.
  function automatic logic [31:0] lat(input logic [1:0] op_class,
                                      input int unsigned load_lat,
                                      input int unsigned md_lat);
    case (op_class)
      OP_LOAD:   return load_lat;
      OP_MULDIV: return md_lat;
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard countdown: loads a latency, decrements to zero and holds there.
// A load in the same cycle wins over the decrement.
module sb_entry #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nz
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_nz  = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: tracks in-flight register writes and stalls ID
// on load-use, mul/div result, mul/div structural and WAW hazards.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = HZ_LOAD_LAT,
  parameter int unsigned MD_LAT   = HZ_MD_LAT,
  parameter int unsigned CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_valid,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic [4:0]  ID_rw,
  input  logic        ID_RegWrite,
  input  logic [1:0]  ID_op_class,
  input  logic        EX_flush,
  output logic        stall,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_bubble,
  output logic        md_busy,
  output logic [15:0] stall_count
);

  logic [CNT_W-1:0] w_cnt [32];
  logic [31:0]      w_nz;
  logic [CNT_W-1:0] w_md_cnt;
  logic             w_md_nz;
  logic [31:0]      w_lat;
  logic [CNT_W-1:0] w_lat_cnt;
  logic             w_raw_a;
  logic             w_raw_b;
  logic             w_struct;
  logic             w_waw;
  logic             w_issue;
  logic [15:0]      r_stall_count;

  assign w_lat     = lat(ID_op_class, LOAD_LAT, MD_LAT);
  assign w_lat_cnt = w_lat[CNT_W-1:0];

  // r0 is never tracked, so its slot reads as permanently idle.
  assign w_cnt[0] = '0;
  assign w_nz[0]  = 1'b0;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    logic w_load;
    assign w_load = w_issue & ID_RegWrite & (ID_rw == 5'(g));

    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_lat_cnt),
      .o_cnt      (w_cnt[g]),
      .o_nz       (w_nz[g])
    );
  end

  sb_entry #(.CNT_W(CNT_W)) u_md_entry (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_issue & (ID_op_class == OP_MULDIV)),
    .i_load_val (CNT_W'(MD_LAT)),
    .o_cnt      (w_md_cnt),
    .o_nz       (w_md_nz)
  );

  assign w_raw_a  = ID_use_rs & w_nz[ID_rs];
  assign w_raw_b  = ID_use_rt & w_nz[ID_rt];
  assign w_struct = (ID_op_class == OP_MULDIV) & (w_md_cnt != '0);
  // A write may issue while an older write to the same register is still
  // pending, as long as the new result cannot land before the old one.
  assign w_waw    = ID_RegWrite & (ID_rw != 5'd0) & (32'(w_cnt[ID_rw]) > w_lat);

  assign stall   = ID_valid & ~EX_flush & (w_raw_a | w_raw_b | w_struct | w_waw);
  assign w_issue = ID_valid & ~stall & ~EX_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign PC_Write     = ~stall;
  assign IF_ID_Write  = ~stall;
  assign ID_EX_bubble = stall | EX_flush;
  assign md_busy      = w_md_nz;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, mul/div, WAW, r0, flush and
// mid-stall reset scenarios with hand-computed stall counts.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        ID_valid;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_use_rs;
  logic        ID_use_rt;
  logic [4:0]  ID_rw;
  logic        ID_RegWrite;
  logic [1:0]  ID_op_class;
  logic        EX_flush;
  logic        stall;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        ID_EX_bubble;
  logic        md_busy;
  logic [15:0] stall_count;

  int checks;
  int failures;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .ID_valid     (ID_valid),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_use_rs    (ID_use_rs),
    .ID_use_rt    (ID_use_rt),
    .ID_rw        (ID_rw),
    .ID_RegWrite  (ID_RegWrite),
    .ID_op_class  (ID_op_class),
    .EX_flush     (EX_flush),
    .stall        (stall),
    .PC_Write     (PC_Write),
    .IF_ID_Write  (IF_ID_Write),
    .ID_EX_bubble (ID_EX_bubble),
    .md_busy      (md_busy),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rw,
                       input logic we, input logic [1:0] cls, input logic fl);
    ID_valid    = v;
    ID_rs       = rs;
    ID_rt       = rt;
    ID_use_rs   = urs;
    ID_use_rt   = urt;
    ID_rw       = rw;
    ID_RegWrite = we;
    ID_op_class = cls;
    EX_flush    = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    idle();
    checks++;
    if (stall !== 1'b0 || PC_Write !== 1'b1 || IF_ID_Write !== 1'b1 ||
        ID_EX_bubble !== 1'b0 || md_busy !== 1'b0 || stall_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs got stall=%b pcw=%b ifid=%b bub=%b md=%b cnt=%0d want 0 1 1 0 0 0",
               stall, PC_Write, IF_ID_Write, ID_EX_bubble, md_busy, stall_count);
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1);
    checks++;
    if (ID_EX_bubble !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_flush_bubble got bub=%b stall=%b want 1 0", ID_EX_bubble, stall);
    end
    idle();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 2'b01, 1'b0);
    step();
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 2'b00, 1'b0);
    checks++;
    if (stall !== 1'b1 || PC_Write !== 1'b0 || IF_ID_Write !== 1'b0 || ID_EX_bubble !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall got stall=%b pcw=%b ifid=%b bub=%b want 1 0 0 1",
               stall, PC_Write, IF_ID_Write, ID_EX_bubble);
    end
    step();
    checks++;
    if (stall !== 1'b0 || PC_Write !== 1'b1 || ID_EX_bubble !== 1'b0) begin
      failures++;
      $display("FAIL load_use_release got stall=%b pcw=%b bub=%b want 0 1 0", stall, PC_Write, ID_EX_bubble);
    end
    step();
    idle();
    checks++;
    if (stall_count !== 16'd1) begin
      failures++;
      $display("FAIL load_use_count got %0d want 1", stall_count);
    end
  endtask

  task automatic test_muldiv();
    int n;
    int busy;
    n = 0;
    busy = 0;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'b10, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (!stall) break;
      n++;
      if (md_busy) busy++;
      step();
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL muldiv_raw_stalls got %0d want 4", n);
    end
    checks++;
    if (busy !== 4 || md_busy !== 1'b0) begin
      failures++;
      $display("FAIL muldiv_busy got cycles=%0d end=%b want 4 0", busy, md_busy);
    end
    step();
    idle();
    checks++;
    if (stall_count !== 16'd5) begin
      failures++;
      $display("FAIL muldiv_count got %0d want 5", stall_count);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'b10, 1'b0);
    step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 2'b10, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (!stall) break;
      n++;
      step();
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL b2b_mul_stalls got %0d want 4", n);
    end
    step();
    idle();
    checks++;
    if (md_busy !== 1'b1 || stall_count !== 16'd9) begin
      failures++;
      $display("FAIL b2b_mul_state got md=%b cnt=%0d want 1 9", md_busy, stall_count);
    end
    for (int k = 0; k < 5; k++) step();
  endtask

  task automatic test_waw();
    int n;
    n = 0;
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 2'b10, 1'b0);
    step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 2'b00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (!stall) break;
      n++;
      step();
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL waw_alu_stalls got %0d want 4", n);
    end
    step();
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 2'b00, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL waw_reader_after got stall=%b want 0", stall);
    end
    step();
    // Load after mul to the same reg: waits only until cnt <= LOAD_LAT.
    n = 0;
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 2'b10, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 2'b01, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (!stall) break;
      n++;
      step();
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL waw_load_stalls got %0d want 3", n);
    end
    step();
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b00, 1'b0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL waw_load_override got stall=%b want 1", stall);
    end
    step();
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL waw_load_release got stall=%b want 0", stall);
    end
    step();
    idle();
    checks++;
    if (stall_count !== 16'd17) begin
      failures++;
      $display("FAIL waw_count got %0d want 17", stall_count);
    end
  endtask

  task automatic test_r0();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 2'b00, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL r0_no_stall got stall=%b want 0", stall);
    end
    step();
    idle();
    checks++;
    if (stall_count !== 16'd17) begin
      failures++;
      $display("FAIL r0_count got %0d want 17", stall_count);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 2'b01, 1'b0);
    step();
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 2'b00, 1'b1);
    checks++;
    if (stall !== 1'b0 || ID_EX_bubble !== 1'b1 || PC_Write !== 1'b1) begin
      failures++;
      $display("FAIL flush_priority got stall=%b bub=%b pcw=%b want 0 1 1", stall, ID_EX_bubble, PC_Write);
    end
    step();
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 2'b00, 1'b0);
    checks++;
    if (stall !== 1'b0 || stall_count !== 16'd17) begin
      failures++;
      $display("FAIL flush_decay got stall=%b cnt=%0d want 0 17", stall, stall_count);
    end
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'b10, 1'b0);
    step();
    idle();
    step();
    checks++;
    if (md_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_busy_before got md=%b want 1", md_busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0);
    checks++;
    if (stall !== 1'b0 || stall_count !== 16'd0 || md_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_clear got stall=%b cnt=%0d md=%b want 0 0 0", stall, stall_count, md_busy);
    end
    step();
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_muldiv();
    test_back_to_back();
    test_waw();
    test_r0();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
